// File: rtl/qspi_read_sequencer.sv
// qspi_read_sequencer
//   Issues quad-output fast reads (0xEB) to a QSPI flash on the uio pad bus.
//   It steers an external nibble sampler with reading, seq_ready and adjust.
//   It packs the returned nibbles into bytes and queues them in a small FIFO.
//
//   Optional feature: define QSPI_CAL_EN to enable the sampler calibration window.
//   When it is enabled, the adjust output is held high for CAL_SCK SCK cycles at DATA entry.
//   When it is not defined, cal is ignored and adjust is tied low.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   rd_start             start pulse; sampled only while IDLE
//   rd_addr[23:0]        flash byte address
//   rd_len[LEN_W-1:0]    bytes to read; 0 completes at once with no flash access
//   cal                  request a calibration window for this read
//   busy                 transaction in progress
//   done                 one-clock pulse at the end of a transaction
//   timeout, overrun     sticky status flags, cleared by an accepted rd_start
//   out_data, out_valid  FIFO head byte and the non-empty flag
//   out_ready            consumer ready
//   uio_out, uio_oe      pad outputs and pad enables
//                        [0]CS_n [1]IO0 [2]IO1 [3]SCK [4]IO2 [5]IO3 [7:6]RAM CS_n
//   reading, seq_ready   to the sampler: CS asserted, and DATA phase
//   adjust               to the sampler: calibration window
//   s_data, s_valid      sampler nibble {IO3,IO2,IO1,IO0} and its strobe
//   dbg_state            current FSM state, for observation
//
// Handshake: a byte leaves the FIFO on any clk where out_valid && out_ready.
//   out_data is stable while out_valid is high and out_ready is low.

module qspi_read_sequencer #(
  parameter int LEN_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 96,
  parameter int CAL_SCK     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_start,
  input  logic [23:0]      rd_addr,
  input  logic [LEN_W-1:0] rd_len,
  input  logic             cal,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             overrun,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe,
  output logic             reading,
  output logic             seq_ready,
  output logic             adjust,
  input  logic [3:0]       s_data,
  input  logic             s_valid,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_MODE  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_CSH   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_BYTE = 8'hEB;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t             state, state_nx;
  logic [1:0]         ph;        // 0,1,2 within one SCK cycle; SCK high on 2
  logic [7:0]         cnt;       // SCK cycles spent in the current state (saturates)
  logic [23:0]        addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   byte_cnt;
  logic [TW-1:0]      q_cnt;     // quiet clks in DATA since the last nibble
  logic               half;
  logic [3:0]         hi_nib;

  logic               sck_last;
  logic               accept;
  logic               finish;
  logic               take;
  logic               push;
  logic               pop;
  logic               full;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;

  assign sck_last = (ph == 2'd2);
  assign accept   = (state == S_IDLE) && rd_start;
  // The read ends when all bytes have been collected or when the quiet timer expired.
  // timeout is cleared on accept, so inside DATA it refers to this transaction only.
  assign finish   = (byte_cnt == len_q) || timeout;
  assign take     = (state == S_DATA) && s_valid && !finish;
  assign push     = take && half;
  assign pop      = out_valid && out_ready;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid = (wr_ptr != rd_ptr);
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != S_IDLE);
  assign reading   = (state == S_CMD) || (state == S_ADDR) || (state == S_MODE) ||
                     (state == S_DUMMY) || (state == S_DATA);
  assign seq_ready = (state == S_DATA);
  assign dbg_state = state;

  // Next state. Every state change except IDLE->CMD happens on the ph==2 clk.
  // As a result, the pads change only on ph==0.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (rd_start && rd_len != '0)   state_nx = S_CMD;
      S_CMD:   if (sck_last && cnt == 8'd7)   state_nx = S_ADDR;
      S_ADDR:  if (sck_last && cnt == 8'd5)   state_nx = S_MODE;
      S_MODE:  if (sck_last && cnt == 8'd1)   state_nx = S_DUMMY;
      S_DUMMY: if (sck_last && cnt == 8'd3)   state_nx = S_DATA;
      S_DATA:  if (sck_last && finish)        state_nx = S_CSH;
      S_CSH:   if (sck_last && cnt == 8'd1)   state_nx = S_IDLE;
      default:                                state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ph       <= 2'd0;
      cnt      <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
      q_cnt    <= '0;
      half     <= 1'b0;
      hi_nib   <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == S_IDLE) ph <= 2'd0;
      else                 ph <= sck_last ? 2'd0 : ph + 2'd1;

      if (state_nx != state)            cnt <= '0;
      else if (sck_last && cnt != '1)   cnt <= cnt + 8'd1;

      done <= (accept && rd_len == '0) || (state == S_CSH && state_nx == S_IDLE);

      if (accept) begin
        addr_q   <= rd_addr;
        len_q    <= rd_len;
        byte_cnt <= '0;
        timeout  <= 1'b0;
        overrun  <= 1'b0;
      end

      if (state == S_DATA) begin
        if (s_valid) begin
          q_cnt <= '0;
        end else if (!finish) begin
          if (q_cnt == TW'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
          else                               q_cnt   <= q_cnt + TW'(1);
        end
        // The first nibble is the high half, and the second completes the byte.
        if (take) begin
          if (!half) begin
            hi_nib <= s_data;
            half   <= 1'b1;
          end else begin
            half     <= 1'b0;
            byte_cnt <= byte_cnt + LEN_W'(1);
          end
        end
      end else begin
        q_cnt <= '0;
        half  <= 1'b0;  // a half byte left at the end is discarded
      end

      // A simultaneous pop frees the slot, so this does not count as an overrun.
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

  // The output FIFO has extra-bit pointers to tell full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && (!full || pop)) wr_ptr <= wr_ptr + 1'b1;
      if (pop)                    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && (!full || pop)) mem[wr_ptr[AW-1:0]] <= {hi_nib, s_data};
  end

`ifdef QSPI_CAL_EN
  logic cal_q;
  always_ff @(posedge clk) begin
    if (!rst_n)      cal_q <= 1'b0;
    else if (accept) cal_q <= cal;
  end
  // cnt restarts at DATA entry, so the window lasts exactly CAL_SCK SCK cycles.
  assign adjust = cal_q && (state == S_DATA) && (cnt < 8'(CAL_SCK));
`else
  logic unused_cal;
  assign unused_cal = cal;
  assign adjust     = 1'b0;
`endif

  // Pad drive
  logic [3:0] io;
  logic [3:0] io_oe;
  logic       cs_n;
  logic       sck;

  always_comb begin
    io    = 4'h0;
    io_oe = 4'h0;
    cs_n  = !reading;
    sck   = reading && sck_last;
    case (state)
      S_CMD: begin
        io[0] = CMD_BYTE[3'd7 - cnt[2:0]];
        io_oe = 4'b0001;
      end
      S_ADDR: begin
        io_oe = 4'b1111;
        case (cnt[2:0])
          3'd0:    io = addr_q[23:20];
          3'd1:    io = addr_q[19:16];
          3'd2:    io = addr_q[15:12];
          3'd3:    io = addr_q[11:8];
          3'd4:    io = addr_q[7:4];
          default: io = addr_q[3:0];
        endcase
      end
      S_MODE:  io_oe = 4'b1111;  // mode nibbles 0x0,0x0 leave continuous-read mode off
      default: ;
    endcase
  end

  assign uio_out = {2'b11, io[3], io[2], sck, io[1], io[0], cs_n};
  assign uio_oe  = {2'b11, io_oe[3], io_oe[2], 1'b1, io_oe[1], io_oe[0], 1'b1};

endmodule
